md5_single_block_ctrl: RTL and testbench

- Front-end sequencer for the `md5core` datapath.
- Accepts a byte message as a stream of 32-bit words with valid/ready handshaking.
- Assembles the padded 448-bit message field and the 64-bit bit-length, then holds both stable on the core inputs while the core computes.
- After a fixed latency it captures the 128-bit hash and returns it to the requester over a valid/ready handshake. Messages are limited to one block (0..55 bytes); longer messages are drained and flagged as errors.

---
 rtl/md5_ctrl_pkg.sv | 21 ++
 rtl/md5_byte_packer.sv | 30 +++
 rtl/md5_single_block_ctrl.sv | 146 ++++++++++++++
 tb/tb_md5_single_block_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_ctrl_pkg.sv
// Shared types and constants for the single-block MD5 front-end controller.
// Message field layout: byte i of the padded message lives at [MSG_W-1-8i -: 8].
package md5_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int MAX_BYTES  = 55;
    localparam int MSG_W      = 448;
    localparam int MSG_BYTES  = MSG_W / 8;
    localparam int LEN_W      = 64;
    localparam int HASH_W     = 128;
    localparam int BYTE_CNT_W = 6;

    localparam logic [7:0] PAD_BYTE = 8'h80;

endpackage

// File: rtl/md5_byte_packer.sv
// Combinational lane inserter: drops up to four stream bytes at byte_cnt and
// optionally the 8'h80 pad marker right after them into the message buffer.
module md5_byte_packer
    import md5_ctrl_pkg::*;
(
    input  logic [MSG_W-1:0]      buffer,
    input  logic [BYTE_CNT_W-1:0] byte_cnt,
    input  logic [31:0]           in_data,
    input  logic [2:0]            n,
    input  logic                  pad_en,
    output logic [MSG_W-1:0]      next_buffer
);

    // Positions past the last message byte simply never match, so an
    // oversized write can never spill outside the 56-byte field.
    always_comb begin
        next_buffer = buffer;
        for (int p = 0; p < MSG_BYTES; p++) begin
            for (int k = 0; k < 4; k++) begin
                if ((k < int'(n)) && (p == int'(byte_cnt) + k)) begin
                    next_buffer[MSG_W-1-8*p -: 8] = in_data[31-8*k -: 8];
                end
            end
            if (pad_en && (p == int'(byte_cnt) + int'(n))) begin
                next_buffer[MSG_W-1-8*p -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/md5_single_block_ctrl.sv
// Sequencer in front of md5core: packs a <=55-byte message into one padded
// block, waits out the core latency, and hands the digest back over valid/ready.
module md5_single_block_ctrl
    import md5_ctrl_pkg::*;
#(
    parameter int CORE_LATENCY = 65
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    input  logic [2:0]        in_bytes,
    output logic [MSG_W-1:0]  core_message,
    output logic [LEN_W-1:0]  core_length,
    input  logic [HASH_W-1:0] core_hash,
    output logic              hash_valid,
    input  logic              hash_ready,
    output logic [HASH_W-1:0] hash,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(CORE_LATENCY - 1);
    localparam logic [BYTE_CNT_W:0] MAX_TOTAL = (BYTE_CNT_W + 1)'(MAX_BYTES);

    state_t                state;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [MSG_W-1:0]      buffer;
    logic [MSG_W-1:0]      packed_buffer;
    logic [CNT_W-1:0]      wait_cnt;
    logic [2:0]            n_eff;
    logic [BYTE_CNT_W:0]   total;
    logic [BYTE_CNT_W:0]   word_end;

    // Non-last words always carry four bytes; a last word clamps its count to 4.
    always_comb begin
        n_eff = 3'd4;
        if (in_last && (in_bytes < 3'd4)) begin
            n_eff = in_bytes;
        end
    end

    assign total    = {1'b0, byte_cnt} + {{(BYTE_CNT_W - 2){1'b0}}, n_eff};
    assign word_end = {1'b0, byte_cnt} + (BYTE_CNT_W + 1)'(4);

    md5_byte_packer u_packer (
        .buffer      (buffer),
        .byte_cnt    (byte_cnt),
        .in_data     (in_data),
        .n           (n_eff),
        .pad_en      (in_last),
        .next_buffer (packed_buffer)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            byte_cnt     <= '0;
            buffer       <= '0;
            core_message <= '0;
            core_length  <= '0;
            hash         <= '0;
            err          <= 1'b0;
            wait_cnt     <= '0;
            hash_valid   <= 1'b0;
            busy         <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (!in_last) begin
                            if (word_end > MAX_TOTAL) begin
                                err   <= 1'b1;
                                busy  <= 1'b1;
                                state <= DRAIN;
                            end else begin
                                buffer   <= packed_buffer;
                                byte_cnt <= byte_cnt + BYTE_CNT_W'(4);
                            end
                        end else if (total <= MAX_TOTAL) begin
                            buffer       <= packed_buffer;
                            core_message <= packed_buffer;
                            core_length  <= {{(LEN_W - BYTE_CNT_W - 4){1'b0}}, total, 3'b000};
                            wait_cnt     <= WAIT_INIT;
                            in_ready     <= 1'b0;
                            busy         <= 1'b1;
                            state        <= WAIT;
                        end else begin
                            err        <= 1'b1;
                            hash       <= '0;
                            hash_valid <= 1'b1;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end

                WAIT: begin
                    if (wait_cnt == '0) begin
                        hash       <= core_hash;
                        hash_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                DRAIN: begin
                    if (in_valid && in_last) begin
                        err        <= 1'b1;
                        hash       <= '0;
                        hash_valid <= 1'b1;
                        in_ready   <= 1'b0;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    if (hash_ready) begin
                        buffer       <= '0;
                        core_message <= '0;
                        core_length  <= '0;
                        byte_cnt     <= '0;
                        err          <= 1'b0;
                        hash         <= '0;
                        wait_cnt     <= '0;
                        hash_valid   <= 1'b0;
                        busy         <= 1'b0;
                        in_ready     <= 1'b1;
                        state        <= LOAD;
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_single_block_ctrl.sv
// Self-checking bench: random and directed messages against a byte-level model
// of MD5 single-block padding, with a registered stub standing in for md5core.
module tb_md5_single_block_ctrl;
    import md5_ctrl_pkg::*;

    localparam int CORE_LATENCY = 65;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              in_last;
    logic [2:0]        in_bytes;
    logic [MSG_W-1:0]  core_message;
    logic [LEN_W-1:0]  core_length;
    logic [HASH_W-1:0] core_hash = '0;
    logic              hash_valid;
    logic              hash_ready;
    logic [HASH_W-1:0] hash;
    logic              err;
    logic              busy;

    int checks = 0;
    int passes = 0;

    logic [7:0]       msg_q[$];
    logic [MSG_W-1:0] lit_msg;
    bit               lit_en;

    md5_single_block_ctrl #(.CORE_LATENCY(CORE_LATENCY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
        .core_message (core_message),
        .core_length  (core_length),
        .core_hash    (core_hash),
        .hash_valid   (hash_valid),
        .hash_ready   (hash_ready),
        .hash         (hash),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [HASH_W-1:0] rotl(input logic [HASH_W-1:0] x, input int s);
        return (x << s) | (x >> (HASH_W - s));
    endfunction

    // Stub core: any cheap mixing function of its inputs, registered once.
    function automatic logic [HASH_W-1:0] stub_hash(input logic [MSG_W-1:0] m, input logic [LEN_W-1:0] l);
        return m[447:320] ^ rotl(m[319:192], 7) ^ rotl(m[191:64], 13) ^ {m[63:0], l} ^ 128'h0123456789ABCDEF_FEDCBA9876543210;
    endfunction

    always @(posedge clk) core_hash <= stub_hash(core_message, core_length);

    function automatic logic [MSG_W-1:0] model_message();
        logic [MSG_W-1:0] m;
        m = '0;
        for (int i = 0; i < msg_q.size(); i++) m[MSG_W-1-8*i -: 8] = msg_q[i];
        m[MSG_W-1-8*msg_q.size() -: 8] = 8'h80;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [MSG_W-1:0] actual, input logic [MSG_W-1:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Streams msg_q as 32-bit words with random idle gaps and junk in unused lanes.
    task automatic applyStimulus();
        int  pos;
        int  n;
        int  guard;
        bit  last;
        logic [31:0] word;
        pos = 0;
        do begin
            last = (msg_q.size() - pos) <= 4;
            n = last ? msg_q.size() - pos : 4;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            word = $urandom;
            for (int k = 0; k < n; k++) word[31-8*k -: 8] = msg_q[pos+k];
            in_data  = word;
            in_last  = last;
            in_valid = 1'b1;
            if (!last) in_bytes = 3'($urandom);
            else if (n == 4 && $urandom_range(0, 1) == 1) in_bytes = 3'($urandom_range(5, 7));
            else in_bytes = 3'(n);
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                checkOutput("in_ready_timeout", 0, 1);
                last = 1'b1;
            end else begin
                @(posedge clk);
                pos += n;
            end
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end while (!last);
    endtask

    task automatic checkResult(input int hold);
        int  len;
        int  cyc;
        bit  ok;
        logic [MSG_W-1:0]  exp_msg;
        logic [LEN_W-1:0]  exp_len;
        logic [HASH_W-1:0] exp_hash;
        len      = msg_q.size();
        ok       = len <= MAX_BYTES;
        exp_msg  = ok ? model_message() : '0;
        exp_len  = ok ? LEN_W'(len * 8) : '0;
        exp_hash = ok ? stub_hash(exp_msg, exp_len) : '0;
        @(negedge clk);
        cyc = 1;
        if (ok) begin
            checkOutput("wait_core_message", core_message, exp_msg);
            checkOutput("wait_core_length", core_length, exp_len);
            checkOutput("wait_in_ready", in_ready, 0);
            checkOutput("wait_busy", busy, 1);
            if (lit_en) checkOutput("literal_message", core_message, lit_msg);
        end
        while (!hash_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("hash_valid_latency", cyc, ok ? CORE_LATENCY + 1 : 1);
        for (int i = 0; i < hold; i++) begin
            checkOutput("hold_hash_valid", hash_valid, 1);
            checkOutput("hold_hash", hash, exp_hash);
            checkOutput("hold_err", err, !ok);
            @(negedge clk);
        end
        checkOutput("done_hash", hash, exp_hash);
        checkOutput("done_err", err, !ok);
        checkOutput("done_core_message", core_message, exp_msg);
        checkOutput("done_core_length", core_length, exp_len);
        checkOutput("done_in_ready", in_ready, 0);
        checkOutput("done_busy", busy, 1);
        hash_ready = 1'b1;
        @(posedge clk);
        #1 hash_ready = 1'b0;
        @(negedge clk);
        checkOutput("exit_in_ready", in_ready, 1);
        checkOutput("exit_hash_valid", hash_valid, 0);
        checkOutput("exit_core_message", core_message, 0);
        checkOutput("exit_core_length", core_length, 0);
        checkOutput("exit_hash", hash, 0);
        checkOutput("exit_err", err, 0);
        checkOutput("exit_busy", busy, 0);
        lit_en = 1'b0;
    endtask

    task automatic randomMessage(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic stringMessage(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    initial begin
        bit seen;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        in_bytes   = '0;
        hash_ready = 1'b0;
        lit_en     = 1'b0;
        lit_msg    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hash_valid", hash_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_core_message", core_message, 0);
        checkOutput("reset_hash", hash, 0);
        rst_n = 1'b1;

        $display("[TB] directed: They are deterministic");
        stringMessage("They are deterministic");
        lit_msg = {184'h54686579206172652064657465726D696E697374696380, 264'h0};
        lit_en  = 1'b1;
        applyStimulus();
        checkResult(2);

        $display("[TB] directed: empty, 55, 56, 64 bytes");
        msg_q.delete();
        lit_msg = {8'h80, 440'h0};
        lit_en  = 1'b1;
        applyStimulus();
        checkResult(0);
        randomMessage(55);
        applyStimulus();
        checkResult(1);
        randomMessage(56);
        applyStimulus();
        checkResult(1);
        randomMessage(64);
        applyStimulus();
        checkResult(10);

        $display("[TB] random lengths");
        for (int t = 0; t < 10; t++) begin
            randomMessage($urandom_range(0, 64));
            applyStimulus();
            checkResult($urandom_range(0, 3));
        end

        $display("[TB] reset during WAIT");
        randomMessage(17);
        applyStimulus();
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_hash_valid", hash_valid, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_core_message", core_message, 0);
        checkOutput("midreset_core_length", core_length, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hash_valid) seen = 1'b1;
        end
        checkOutput("no_pulse_after_reset", seen, 0);
        stringMessage("abc");
        applyStimulus();
        @(negedge clk);
        checkOutput("abc_core_length", core_length, 64'h18);
        checkOutput("abc_byte3_pad", core_message[MSG_W-1-24 -: 8], 8'h80);
        repeat (CORE_LATENCY + 2) @(negedge clk);
        checkOutput("abc_hash_valid", hash_valid, 1);
        checkOutput("abc_hash", hash, stub_hash(model_message(), 64'h18));
        hash_ready = 1'b1;
        @(posedge clk);
        #1 hash_ready = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
